vram_arbiter: RTL and testbench

Single-port video-RAM scheduler between the VGA timing generator and the game logic. Every active-display cycle it fetches the framebuffer word for the pixel being scanned out and returns the 1-bit pixel to the VGA colour path. During blanking it shares the RAM between a game-logic writer (sprite/ground drawing) and a game-logic reader (collision probes) by round-robin. It also emits a one-cycle frame tick at the start of vertical blanking to pace the game update.

---
 rtl/vram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter
//
// Single-port video-RAM scheduler. Scanout from the VGA timing generator
// always owns the RAM port while rdn is low. During blanking the port is
// shared round-robin between a game-logic writer and a game-logic reader.
// A one-cycle frame_tick marks the start of vertical blanking.
//
// Build option:
//   VRAM_HBLANK_WR_EN  defined   -> game access in every blanking cycle (rdn=1)
//                      undefined -> game access in vertical blanking only
//
// Ports:
//   vga_clk, rst        pixel clock, synchronous active-high reset
//   rdn                 scanout strobe (active low)
//   row_addr, col_addr  pixel being scanned out
//   px, px_valid        registered pixel, two cycles after the scan cycle
//   frame_tick          one-cycle pulse at start of vertical blanking
//   wr_req/addr/data    game writer; wr_gnt = write performed this cycle
//   rd_req/addr         game reader; rd_gnt = read issued this cycle
//   rd_data, rd_valid   read result, two cycles after rd_gnt
//   ram_addr/we/wdata   RAM command port
//   ram_rdata           RAM read data (one-cycle synchronous read)

module vram_arbiter #(
    parameter int WORDS_PER_ROW = 20,
    parameter int ROWS          = 480,
    parameter int AW            = 14
) (
    input  logic          vga_clk,
    input  logic          rst,
    input  logic          rdn,
    input  logic [8:0]    row_addr,
    input  logic [9:0]    col_addr,
    output logic          px,
    output logic          px_valid,
    output logic          frame_tick,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam logic       WR_SIDE  = 1'b0;
    localparam logic       RD_SIDE  = 1'b1;
    localparam logic [8:0] LAST_ROW = 9'(ROWS - 1);

    logic          rdn_d;
    logic [8:0]    row_q;
    logic          in_vblank;
    logic          last;
    logic          scan_d;
    logic [4:0]    col_d;
    logic          rd_pend;
    logic [AW-1:0] scan_addr;
    logic          vb_set;
    logic          win;
    logic          pick_wr;

    // 32 pixels per word, so the word column is col_addr[9:5].
    generate
        if (WORDS_PER_ROW == 20) begin : g_scan_shift
            logic [13:0] scan_sum;
            // row*20 as (row<<4)+(row<<2); max 479*20+19 = 9599 fits 14 bits
            assign scan_sum = {1'b0, row_addr, 4'b0000}
                            + {3'b000, row_addr, 2'b00}
                            + {9'b0, col_addr[9:5]};
            assign scan_addr = AW'(scan_sum);
        end else begin : g_scan_mul
            assign scan_addr = AW'(32'(row_addr) * WORDS_PER_ROW + 32'(col_addr[9:5]));
        end
    endgenerate

    // Rising rdn after the last active row opens vertical blanking. The
    // window is already open on that very cycle, ahead of in_vblank.
    assign vb_set = rdn & ~rdn_d & (row_q == LAST_ROW);

`ifdef VRAM_HBLANK_WR_EN
    assign win = rdn & ~rst;
`else
    assign win = rdn & ~rst & (in_vblank | vb_set);
`endif

    // Writer wins when alone, or on a tie when the reader went last.
    assign pick_wr = wr_req & (~rd_req | (last == RD_SIDE));
    assign wr_gnt  = win & pick_wr;
    assign rd_gnt  = win & rd_req & ~pick_wr;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!rdn) begin
            ram_addr = scan_addr;
        end else if (wr_gnt) begin
            ram_addr  = wr_addr;
            ram_we    = 1'b1;
            ram_wdata = wr_data;
        end else if (rd_gnt) begin
            ram_addr = rd_addr;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rdn_d      <= 1'b1;
            row_q      <= '0;
            in_vblank  <= 1'b1;
            frame_tick <= 1'b0;
            last       <= RD_SIDE;
            scan_d     <= 1'b0;
            col_d      <= '0;
            px         <= 1'b0;
            px_valid   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rdn_d <= rdn;
            if (!rdn) begin
                row_q <= row_addr;
            end

            if (vb_set) begin
                in_vblank <= 1'b1;
            end else if (!rdn && rdn_d) begin
                in_vblank <= 1'b0;
            end
            frame_tick <= vb_set;

            if (wr_gnt) begin
                last <= WR_SIDE;
            end else if (rd_gnt) begin
                last <= RD_SIDE;
            end

            // Pixel pipeline: address in cycle t, data back in t+1, px at t+2.
            scan_d   <= ~rdn;
            col_d    <= col_addr[4:0];
            px_valid <= scan_d;
            if (scan_d) begin
                px <= ram_rdata[col_d];
            end

            // Game read pipeline with the same two-cycle shape.
            rd_pend  <= rd_gnt;
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    localparam int AW = 14;
`ifdef VRAM_HBLANK_WR_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic          vga_clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdn = 1'b1;
    logic [8:0]    row_addr = '0;
    logic [9:0]    col_addr = '0;
    logic          px, px_valid, frame_tick;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          wr_gnt;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    vram_arbiter #(.WORDS_PER_ROW(20), .ROWS(480), .AW(AW)) dut (
        .vga_clk(vga_clk), .rst(rst), .rdn(rdn),
        .row_addr(row_addr), .col_addr(col_addr),
        .px(px), .px_valid(px_valid), .frame_tick(frame_tick),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 vga_clk = ~vga_clk;

    // RAM seen by the DUT, and the model's own idea of what it holds.
    logic [31:0] mem    [0:16383];
    logic [31:0] shadow [0:16383];

    always @(posedge vga_clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t px_q[$];
    exp_t rd_q[$];
    int   tick_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int mon_cyc = 0;
    bit mon_en = 1'b0;

    // model state
    bit m_last = 1'b1;      // 1 = reader went last
    bit m_vb = 1'b1;
    bit m_prev_rdn = 1'b1;
    int m_last_row = 0;
    int last_wr_a = 0;

    // requester control
    int req_mode = 0;       // 0 none, 1 always, 2 random
    bit force_wr = 1'b0, force_rd = 1'b0;
    bit wr_done = 1'b0, rd_done = 1'b0;

    // ---------------- monitor ----------------
    always @(posedge vga_clk) begin
        mon_cyc = mon_cyc + 1;
        #2;
        if (mon_en) begin
            if (px_q.size() > 0 && px_q[0].cyc == mon_cyc) begin
                n_cmp++;
                if (px_valid !== 1'b1 || px !== px_q[0].val[0]) begin
                    n_bad++;
                    $display("FAIL px cyc=%0d got valid=%0b px=%0b want valid=1 px=%0b",
                             mon_cyc, px_valid, px, px_q[0].val[0]);
                end
                void'(px_q.pop_front());
            end else if (px_valid !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL px_unexpected cyc=%0d got valid=%0b want 0", mon_cyc, px_valid);
            end

            if (rd_q.size() > 0 && rd_q[0].cyc == mon_cyc) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || rd_data !== rd_q[0].val) begin
                    n_bad++;
                    $display("FAIL rd_data cyc=%0d got valid=%0b data=%h want valid=1 data=%h",
                             mon_cyc, rd_valid, rd_data, rd_q[0].val);
                end
                void'(rd_q.pop_front());
            end else if (rd_valid !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_valid_unexpected cyc=%0d got %0b want 0", mon_cyc, rd_valid);
            end

            if (tick_q.size() > 0 && tick_q[0] == mon_cyc) begin
                n_cmp++;
                if (frame_tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL frame_tick cyc=%0d got %0b want 1", mon_cyc, frame_tick);
                end
                void'(tick_q.pop_front());
            end else if (frame_tick !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL frame_tick_unexpected cyc=%0d got %0b want 0", mon_cyc, frame_tick);
            end
        end
    end

    // ---------------- requesters ----------------
    function automatic logic [AW-1:0] pick_wr_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(9600, 16383));
        return AW'($urandom_range(0, 1999));
    endfunction

    task automatic new_wr();
        wr_req  = 1'b1;
        wr_addr = pick_wr_addr();
        wr_data = $urandom;
        last_wr_a = int'(wr_addr);
    endtask

    task automatic new_rd();
        rd_req  = 1'b1;
        rd_addr = ($urandom_range(0, 1) == 0) ? AW'(last_wr_a) : pick_wr_addr();
    endtask

    // ---------------- driver + reference model ----------------
    task automatic step(input bit do_rst, input bit scan, input int row, input int col);
        int   k;
        bit   win, gw, gr;
        int   exp_addr;
        exp_t e;
        @(negedge vga_clk);
        k = mon_cyc + 1;

        if (wr_done) begin wr_req = 1'b0; wr_done = 1'b0; end
        if (rd_done) begin rd_req = 1'b0; rd_done = 1'b0; end
        if (force_wr && !wr_req) new_wr();
        if (force_rd && !rd_req) new_rd();
        force_wr = 1'b0;
        force_rd = 1'b0;
        if (req_mode == 1) begin
            if (!wr_req) new_wr();
            if (!rd_req) new_rd();
        end else if (req_mode == 2) begin
            if (!wr_req && $urandom_range(0, 3) == 0) new_wr();
            if (!rd_req && $urandom_range(0, 3) == 0) new_rd();
        end

        rst      = do_rst;
        rdn      = !scan;
        row_addr = 9'(row);
        col_addr = 10'(col);

        win = 1'b0;
        if (do_rst) begin
            m_last = 1'b1; m_vb = 1'b1; m_prev_rdn = 1'b1;
            px_q.delete(); rd_q.delete(); tick_q.delete();
        end else if (scan) begin
            m_vb = 1'b0; m_last_row = row; m_prev_rdn = 1'b0;
            e.cyc = k + 1;
            e.val = {31'b0, shadow[row * 20 + col / 32][col % 32]};
            px_q.push_back(e);
        end else begin
            if (!m_prev_rdn && m_last_row == 479) begin
                m_vb = 1'b1;
                tick_q.push_back(k);
            end
            m_prev_rdn = 1'b1;
            win = m_vb || HB;
        end

        gw = win && wr_req && (!rd_req || m_last);
        gr = win && rd_req && !gw;

        #1;
        exp_addr = scan ? (row * 20 + col / 32) : gw ? int'(wr_addr) : gr ? int'(rd_addr) : 0;
        n_cmp++;
        if (wr_gnt !== gw || rd_gnt !== gr || ram_we !== gw || (gw && ram_wdata !== wr_data)) begin
            n_bad++;
            $display("FAIL grant cyc=%0d got wr_gnt=%0b rd_gnt=%0b we=%0b want wr_gnt=%0b rd_gnt=%0b we=%0b",
                     k, wr_gnt, rd_gnt, ram_we, gw, gr, gw);
        end
        n_cmp++;
        if (int'(ram_addr) != exp_addr) begin
            n_bad++;
            $display("FAIL ram_addr cyc=%0d got %0d want %0d", k, ram_addr, exp_addr);
        end

        if (gw) begin
            shadow[wr_addr] = wr_data;
            m_last = 1'b0;
            wr_done = 1'b1;
        end
        if (gr) begin
            e.cyc = k + 1;
            e.val = shadow[rd_addr];
            rd_q.push_back(e);
            m_last = 1'b1;
            rd_done = 1'b1;
        end
    endtask

    task automatic check_reset(input string tag);
        n_cmp++;
        if (px !== 1'b0 || px_valid !== 1'b0 || frame_tick !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_%s got px=%0b px_valid=%0b tick=%0b rd_valid=%0b rd_data=%h want all 0",
                     tag, px, px_valid, frame_tick, rd_valid, rd_data);
        end
    endtask

    task automatic scan_line(input int row, input int ncols, input int hb);
        for (int c = 0; c < ncols; c++) step(1'b0, 1'b1, row, c);
        for (int h = 0; h < hb; h++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic drain();
        req_mode = 0;
        for (int i = 0; i < 8 && (wr_req || rd_req || wr_done || rd_done); i++) blank(1);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        mem[2003]    = 32'h0000_0001;
        shadow[2003] = 32'h0000_0001;

        // reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0);
        mon_en = 1'b1;
        blank(1);
        check_reset("initial");

        // round-robin from reset: W first, then alternating
        req_mode = 1;
        blank(10);
        drain();

        // reset the cycle after a read grant
        force_rd = 1'b1;
        blank(1);
        step(1'b1, 1'b0, 0, 0);
        blank(1);
        check_reset("mid_read");
        blank(3);

        // frame 1
        req_mode = 2;
        scan_line(3, 64, 16);
        scan_line(50, 64, 16);
        scan_line(100, 128, 16);
        force_wr = 1'b1;
        scan_line(479, 640, 16);
        blank(40);

        // frame 2
        force_rd = 1'b1;
        scan_line(7, 640, 16);
        scan_line(200, 64, 16);
        scan_line(479, 32, 0);
        blank(30);

        // frame 3: row 478 must not tick
        scan_line(478, 32, 12);
        scan_line(479, 32, 0);
        blank(20);

        drain();
        blank(4);

        n_cmp++;
        if (px_q.size() != 0 || rd_q.size() != 0 || tick_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got px=%0d rd=%0d tick=%0d pending want 0",
                     px_q.size(), rd_q.size(), tick_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
